// File: rtl/dm_access.sv
// rtl/dm_access.sv - M-stage data memory with byte/half/word access and W-stage load register
module dm_access #(
  parameter int DM_WORDS = 2048,
  parameter int AW       = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En,
  input  logic        Clr,
  input  logic [31:0] IR_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] WriteData,
  output logic [31:0] DR_WD,
  output logic        AddrErr_W
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  // One past the last legal byte address; 33 bits so DM_WORDS*4 never overflows.
  localparam logic [32:0] LIMIT = 33'(DM_WORDS) << 2;

  logic [31:0] mem [0:DM_WORDS-1];

  logic [5:0]    opcode;
  logic          is_load, is_store, sz_word, sz_half, sgn;
  logic [AW-1:0] widx;
  logic [1:0]    off;
  logic          range_ok, align_ok, err;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rword, rshift, ext;
  logic [15:0]   rhalf;
  logic          unused_bits;

  assign opcode      = IR_M[31:26];
  assign unused_bits = ^IR_M[25:0];

  // Opcode decode into access class, size and signedness.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_word  = 1'b0;
    sz_half  = 1'b0;
    sgn      = 1'b0;
    case (opcode)
      OP_LW:  begin is_load  = 1'b1; sz_word = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; sz_half = 1'b1; sgn = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
      OP_LB:  begin is_load  = 1'b1; sgn = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; end
      OP_SW:  begin is_store = 1'b1; sz_word = 1'b1; end
      OP_SH:  begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SB:  begin is_store = 1'b1; end
      default: ;
    endcase
  end

  assign widx     = AO_M[AW+1:2];
  assign off      = AO_M[1:0];
  // Full 32-bit compare: high addresses must fault, never alias onto low words.
  assign range_ok = ({1'b0, AO_M} < LIMIT);
  assign align_ok = sz_word ? (off == 2'b00) : (sz_half ? ~off[0] : 1'b1);
  assign err      = (is_load | is_store) & ~(range_ok & align_ok);

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b0000;
    wlane = WriteData;
    if (sz_word) begin
      be    = 4'b1111;
      wlane = WriteData;
    end else if (sz_half) begin
      be    = off[1] ? 4'b1100 : 4'b0011;
      wlane = {2{WriteData[15:0]}};
    end else begin
      be    = 4'b0001 << off;
      wlane = {4{WriteData[7:0]}};
    end
  end

  // RAM: cleared on reset, byte-masked write for valid enabled stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else if (En && is_store && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign rword  = mem[widx];
  assign rshift = rword >> {off, 3'b000};
  assign rhalf  = off[1] ? rword[31:16] : rword[15:0];

  // Lane extraction and sign/zero extension of the load result.
  always_comb begin
    ext = rword;
    if (sz_word)      ext = rword;
    else if (sz_half) ext = {{16{sgn & rhalf[15]}}, rhalf};
    else              ext = {{24{sgn & rshift[7]}}, rshift[7:0]};
  end

  // W-stage register: flush has priority, otherwise advance on En.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DR_WD     <= '0;
      AddrErr_W <= 1'b0;
    end else if (Clr) begin
      DR_WD     <= '0;
      AddrErr_W <= 1'b0;
    end else if (En) begin
      DR_WD     <= (is_load && !err) ? ext : 32'h0;
      AddrErr_W <= err;
    end
  end

endmodule

// File: tb/tb_dm_access.sv
// tb/tb_dm_access.sv - scoreboard testbench for dm_access
module tb_dm_access;

  localparam int DM_WORDS = 2048;
  localparam int NBYTES   = DM_WORDS * 4;
  localparam logic [31:0] LIM = 32'(NBYTES);

  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
  localparam logic [5:0] NOP = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_n, En, Clr;
  logic [31:0] IR_M, AO_M, WriteData;
  logic [31:0] DR_WD;
  logic        AddrErr_W;

  typedef struct {
    logic [31:0] dr;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  ref_mem [0:NBYTES-1];
  logic [31:0] prev_dr = 32'h0;
  logic        prev_err = 1'b0;

  dm_access #(.DM_WORDS(DM_WORDS), .AW(11)) dut (
    .clk(clk), .reset(rst_n), .En(En), .Clr(Clr),
    .IR_M(IR_M), .AO_M(AO_M), .WriteData(WriteData),
    .DR_WD(DR_WD), .AddrErr_W(AddrErr_W)
  );

  always #5 clk = ~clk;

  // Monitor: each edge retires exactly one expected W-stage result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (DR_WD !== e.dr || AddrErr_W !== e.err) begin
          n_bad++;
          $display("FAIL %s: got DR_WD=%h AddrErr_W=%b, want DR_WD=%h AddrErr_W=%b",
                   e.tag, DR_WD, AddrErr_W, e.dr, e.err);
        end
      end
    end
  end

  // Drive one cycle; reference model is byte-addressed and tracks the W registers.
  task automatic step(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] wd,
                      input bit en, input bit clr, input bit rn,
                      input bit hand, input logic [31:0] hdr, input logic herr, input string tag);
    bit          ld, st, sgn, e;
    int          sz, a;
    logic [31:0] v, ndr;
    logic        nerr;
    exp_t        x;
    IR_M = {opc, 26'h0}; AO_M = addr; WriteData = wd; En = en; Clr = clr; rst_n = rn;
    ld = 0; st = 0; sgn = 0; sz = 1;
    case (opc)
      LW:  begin ld = 1; sz = 4; end
      LH:  begin ld = 1; sz = 2; sgn = 1; end
      LHU: begin ld = 1; sz = 2; end
      LB:  begin ld = 1; sz = 1; sgn = 1; end
      LBU: begin ld = 1; sz = 1; end
      SW:  begin st = 1; sz = 4; end
      SH:  begin st = 1; sz = 2; end
      SB:  begin st = 1; sz = 1; end
      default: ;
    endcase
    e = (ld || st) && (addr >= LIM || (int'(addr[1:0]) % sz) != 0);
    a = e ? 0 : int'(addr[12:0]);
    v = 32'h0;
    if (ld && !e) begin
      if (sz == 4)      v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      else if (sz == 2) v = {{16{sgn & ref_mem[a+1][7]}}, ref_mem[a+1], ref_mem[a]};
      else              v = {{24{sgn & ref_mem[a][7]}}, ref_mem[a]};
    end
    if (!rn) begin
      for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h0;
      ndr = 32'h0; nerr = 1'b0;
    end else begin
      if (clr)     begin ndr = 32'h0; nerr = 1'b0; end
      else if (en) begin ndr = v;     nerr = e;    end
      else         begin ndr = prev_dr; nerr = prev_err; end
      if (en && st && !e)
        for (int k = 0; k < sz; k++) ref_mem[a+k] = wd[8*k +: 8];
    end
    if (hand) begin ndr = hdr; nerr = herr; end
    prev_dr = ndr; prev_err = nerr;
    x.dr = ndr; x.err = nerr; x.tag = tag;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic chk(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] hdr, input logic herr, input string tag);
    step(opc, addr, wd, 1'b1, 1'b0, 1'b1, 1'b1, hdr, herr, tag);
  endtask

  logic [5:0] ops [0:8];

  initial begin
    ops[0] = LW; ops[1] = LH; ops[2] = LHU; ops[3] = LB; ops[4] = LBU;
    ops[5] = SW; ops[6] = SH; ops[7] = SB;  ops[8] = NOP;
    rst_n = 1'b0; En = 1'b0; Clr = 1'b0; IR_M = '0; AO_M = '0; WriteData = '0;
    @(negedge clk);
    step(NOP, 0, 0, 1, 0, 0, 1, 32'h0, 1'b0, "reset");
    step(NOP, 0, 0, 1, 0, 0, 1, 32'h0, 1'b0, "reset_hold");

    for (int i = 0; i < 8; i++) chk(LW, 32'(i * 1024), 0, 32'h0, 1'b0, "lw_after_reset");

    chk(SW,  32'h10, 32'h80FF7F01, 32'h0, 1'b0, "sw_10");
    chk(LB,  32'h11, 0, 32'h0000007F, 1'b0, "lb_11");
    chk(LB,  32'h13, 0, 32'hFFFFFF80, 1'b0, "lb_13");
    chk(LBU, 32'h13, 0, 32'h00000080, 1'b0, "lbu_13");
    chk(LH,  32'h12, 0, 32'hFFFF80FF, 1'b0, "lh_12");
    chk(LHU, 32'h10, 0, 32'h00007F01, 1'b0, "lhu_10");
    chk(LW,  32'h10, 0, 32'h80FF7F01, 1'b0, "lw_10");

    chk(SW, 32'h20, 32'h11223344, 32'h0, 1'b0, "sw_20");
    chk(SB, 32'h22, 32'h000000AB, 32'h0, 1'b0, "sb_22");
    chk(SH, 32'h20, 32'h0000BEEF, 32'h0, 1'b0, "sh_20");
    chk(LW, 32'h20, 0, 32'h11ABBEEF, 1'b0, "lw_20_merge");
    chk(NOP, 32'h20, 0, 32'h0, 1'b0, "nonmem_clears");

    chk(LW, 32'h21, 0, 32'h0, 1'b1, "lw_misal_21");
    chk(LH, 32'h23, 0, 32'h0, 1'b1, "lh_misal_23");
    chk(SW, 32'h26, 32'hFFFFFFFF, 32'h0, 1'b1, "sw_misal_26");
    chk(LW, LIM, 0, 32'h0, 1'b1, "lw_out_of_range");
    chk(SB, LIM, 32'h000000FF, 32'h0, 1'b1, "sb_out_of_range");
    chk(LW, 32'h24, 0, 32'h0, 1'b0, "lw_24_untouched");
    chk(LW, 32'h20, 0, 32'h11ABBEEF, 1'b0, "lw_20_untouched");
    chk(LW, 32'h0, 0, 32'h0, 1'b0, "lw_0_no_alias");
    chk(SB, LIM - 1, 32'h0000005A, 32'h0, 1'b0, "sb_last_byte");
    chk(LB, LIM - 1, 0, 32'h0000005A, 1'b0, "lb_last_byte");

    chk(LW, 32'h10, 0, 32'h80FF7F01, 1'b0, "lw_before_hold");
    step(SW, 32'h40, 32'hDEADBEEF, 0, 0, 1, 1, 32'h80FF7F01, 1'b0, "en0_hold");
    chk(LW, 32'h21, 0, 32'h0, 1'b1, "err_before_hold");
    step(NOP, 0, 0, 0, 0, 1, 1, 32'h0, 1'b1, "en0_hold_err");
    chk(LW, 32'h40, 0, 32'h0, 1'b0, "lw_40_not_written");
    chk(LW, 32'h10, 0, 32'h80FF7F01, 1'b0, "lw_before_clr");
    step(LW, 32'h10, 0, 1, 1, 1, 1, 32'h0, 1'b0, "clr_with_en");
    chk(LW, 32'h21, 0, 32'h0, 1'b1, "err_before_clr");
    step(NOP, 0, 0, 0, 1, 1, 1, 32'h0, 1'b0, "clr_without_en");

    chk(SW, 32'h100, 32'h12345678, 32'h0, 1'b0, "sw_100");
    chk(LW, 32'h100, 0, 32'h12345678, 1'b0, "lw_100");
    step(SW, 32'h104, 32'hCAFEF00D, 1, 0, 0, 1, 32'h0, 1'b0, "store_during_reset");
    chk(LW, 32'h100, 0, 32'h0, 1'b0, "lw_100_after_reset");
    chk(LW, 32'h104, 0, 32'h0, 1'b0, "lw_104_lost");

    for (int n = 0; n < 10000; n++) begin
      logic [31:0] addr;
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      addr = LIM - 32'd8 + 32'($urandom_range(0, 15));
      else if (r == 1) addr = $urandom;
      else             addr = 32'($urandom_range(0, 255));
      step(ops[$urandom_range(0, 8)], addr, $urandom,
           $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, 1'b1,
           1'b0, 32'h0, 1'b0, "random");
    end

    step(NOP, 0, 0, 0, 0, 1, 1, prev_dr, prev_err, "drain");
    for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_access.md
Name: dm_access

Overview:
- Memory-stage data memory block for the 5-stage MIPS pipeline. It is the consumer of the forwarded store data (WriteData) produced by the M-stage forwarding mux.
- Performs byte/halfword/word stores into an internal word-addressed RAM.
- Performs loads with sign/zero extension and registers the result into the W stage as DR_WD. DR_WD is the load value the W-stage forwarding and register-write paths consume.
- Flags misaligned or out-of-range accesses to the W stage.

Parameters:
- DM_WORDS, 2048, number of 32-bit words in the RAM. Byte address range is 0 .. DM_WORDS*4-1.
- AW, 11, word-index width; must equal clog2(DM_WORDS).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- En  input  1  M->W advance enable. 0 = hold W outputs and suppress any store.
- Clr  input  1  synchronous flush of the W-stage outputs
- IR_M  input  32  instruction in M stage; opcode is IR_M[31:26]
- AO_M  input  32  ALU result in M stage, used as the byte address
- WriteData  input  32  store data after M-stage forwarding
- DR_WD  output  32  extended load data, W stage
- AddrErr_W  output  1  W-stage flag: the access in the previous M instruction was misaligned or out of range

Behaviour:
- Decode from IR_M[31:26]:
  - Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - Stores: sw 101011, sh 101001, sb 101000.
  - Any other opcode is a non-memory instruction: no access, AddrErr=0.
- Address checks:
  - widx = AO_M[AW+1:2]; off = AO_M[1:0].
  - range_ok = (AO_M < DM_WORDS*4).
  - align_ok: word requires off==0; half requires off[0]==0; byte is always aligned.
  - err = memory op and !(range_ok & align_ok).
- Store (combinational byte enables, write on rising clk edge when En=1, store, and !err):
  - sw: be=1111, data=WriteData.
  - sh: be = off[1] ? 1100 : 0011; the selected halfword gets WriteData[15:0].
  - sb: be = 0001<<off; the selected byte gets WriteData[7:0].
  - Unselected bytes are unchanged.
  - A faulting store writes nothing.
- Load read path:
  - Combinational read of mem[widx] in M.
  - Extract the byte/half at off: byte lane off*8; half lane off[1]*16.
  - Extend: lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - The result is registered into DR_WD at the rising edge. Load-to-W latency is exactly 1 cycle.
- W register update at each rising edge:
  - Clr=1 (takes priority over En): DR_WD<=0, AddrErr_W<=0.
  - Else if En=1: DR_WD <= (load & !err) ? extended : 0; AddrErr_W <= err.
  - Else: hold both.
- Reset (reset=0, asynchronous): DR_WD=0, AddrErr_W=0, every RAM word cleared to 0.
  - A store whose edge coincides with an asserted reset is lost.
  - Release of reset is synchronous to the next edge; no access occurs while reset=0.
- Store followed by load to the same word on the next cycle: the load returns the newly written data, because the write completes at the edge before the read.
- Address wrap: no wrap. Any address >= DM_WORDS*4 faults; it is never aliased onto low words.
- Non-memory instructions with En=1 load DR_WD=0 and AddrErr_W=0.

Test Plan:
- Reset, then load every 256th word with lw → DR_WD=0x00000000, AddrErr_W=0. Assert reset mid-run after a store → that word reads 0 afterwards.
- sw 0x80FF7F01 to addr 0x10, then the next cycle lb/lbu/lh/lhu/lw from 0x10..0x13:
  - lb 0x11 → 0xFFFFFF7F? No: byte at 0x11 is 0x7F, so lb 0x11 → 0x0000007F.
  - lb 0x13 → 0xFFFFFF80.
  - lbu 0x13 → 0x00000080.
  - lh 0x12 → 0xFFFF80FF.
  - lhu 0x10 → 0x00007F01.
  - lw 0x10 → 0x80FF7F01.
  - Each result appears exactly 1 cycle after the load is in M.
- sw 0x11223344 @0x20, sb 0xAB @0x22, sh 0xBEEF @0x20, then lw 0x20 → 0x11ABBEEF.
- lw @0x21, lh @0x23, sw @0x26, and lw @DM_WORDS*4 → AddrErr_W=1, DR_WD=0, RAM unchanged (verified by an aligned lw afterwards).
- En=0 during sw 0xDEADBEEF @0x40 → no write (lw 0x40 later → 0), DR_WD/AddrErr_W hold their previous values. Clr=1 with En=1 during a valid lw → DR_WD=0.
- Random mix of 10k aligned/misaligned loads and stores compared against a byte-array reference model; zero mismatches.
